// File: rtl/sample_packer_pkg.sv
// Shared types and constants for the sample packer: FSM encoding, header magic
// and byte-lane placement inside a packed 32-bit word.
package sample_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_PAD  = 2'd3
    } state_t;

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hCAFE;
    localparam int          LANE_W            = 8;

    // Lane 0 lands in bits [7:0], lane 3 in bits [31:24].
    function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[32'(lane) * LANE_W +: LANE_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/sample_packer_sync_fifo.sv
// Single-clock show-ahead FIFO on a distributed-RAM array with async read.
// A push against a full FIFO is accepted only when a pop frees the head slot.
module sample_packer_sync_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sample_packer.sv
// Capture stage: samples ch_data at a programmable rate, packs 4 bytes per word,
// frames each session with a header word and buffers words for the DQ writer.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 6,
    parameter int          BURST_WORDS = 16,
    parameter logic [15:0] HDR_MAGIC   = HDR_MAGIC_DEFAULT
) (
    input  logic                  clk_pll,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [15:0]           sample_div,
    input  logic [7:0]            ch_data,
    input  logic                  rd_pop,
    output logic [31:0]           rd_data,
    output logic                  rd_empty,
    output logic [DEPTH_LOG2:0]   rd_level,
    output logic                  burst_ready,
    output logic                  overflow,
    output logic [15:0]           drop_ctr
);

    localparam logic [DEPTH_LOG2:0] BURST_LVL = (DEPTH_LOG2 + 1)'(BURST_WORDS);

    state_t      state_q, state_d;
    logic        enable_q;
    logic [1:0]  pack_idx_q, pack_idx_d;
    logic [31:0] pack_q, pack_d;
    logic [15:0] div_q, div_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [15:0] seq_q, seq_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_ctr_q, drop_ctr_d;
    logic        push, drop, fifo_full;
    logic [31:0] push_word;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        pack_idx_d = pack_idx_q;
        pack_d     = pack_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        seq_d      = seq_q;
        push       = 1'b0;
        push_word  = pack_q;
        unique case (state_q)
            ST_IDLE: if (enable && !enable_q) state_d = ST_HDR;
            ST_HDR: begin
                push       = 1'b1;
                push_word  = {HDR_MAGIC, seq_q};
                seq_d      = seq_q + 16'd1;
                div_d      = sample_div;
                div_cnt_d  = '0;
                pack_idx_d = '0;
                pack_d     = '0;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = (pack_idx_q != 2'd0) ? ST_PAD : ST_IDLE;
                end else if (div_cnt_q == '0) begin
                    pack_d    = insert_lane(pack_q, pack_idx_q, ch_data);
                    div_cnt_d = div_q;
                    if (pack_idx_q == 2'd3) begin
                        push       = 1'b1;
                        push_word  = pack_d;
                        pack_d     = '0;
                        pack_idx_d = '0;
                    end else begin
                        pack_idx_d = pack_idx_q + 2'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 16'd1;
                end
            end
            ST_PAD: begin
                // Unfilled upper lanes are already zero since pack is cleared per word.
                push    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d    = ST_IDLE;
            pack_idx_d = '0;
            pack_d     = '0;
            push       = 1'b0;
        end

        drop       = push && fifo_full && !rd_pop;
        overflow_d = overflow_q;
        drop_ctr_d = drop_ctr_q;
        if (flush) begin
            overflow_d = 1'b0;
            drop_ctr_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            drop_ctr_d = sat_inc(drop_ctr_q);
        end
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            pack_idx_q <= '0;
            div_cnt_q  <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_ctr_q <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable;
            pack_idx_q <= pack_idx_d;
            div_cnt_q  <= div_cnt_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_ctr_q <= drop_ctr_d;
        end
    end

    always_ff @(posedge clk_pll) begin
        pack_q <= pack_d;
        div_q  <= div_d;
    end

    sample_packer_sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (32)
    ) u_fifo (
        .clk_i  (clk_pll),
        .rst_i  (reset),
        .flush_i(flush),
        .push_i (push),
        .wdata_i(push_word),
        .pop_i  (rd_pop),
        .rdata_o(rd_data),
        .empty_o(rd_empty),
        .full_o (fifo_full),
        .level_o(rd_level)
    );

    assign burst_ready = (rd_level >= BURST_LVL);
    assign overflow    = overflow_q;
    assign drop_ctr    = drop_ctr_q;

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: a 64-word instance (A) and a 4-word instance (B),
// session vectors from a table, a scoreboard queue of expected FIFO words.
module tb_sample_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_en, a_flush, a_pop;
    logic [15:0] a_div;
    logic [7:0]  a_ch;
    logic [31:0] a_data;
    logic        a_empty, a_burst, a_ovf;
    logic [6:0]  a_level;
    logic [15:0] a_drop;

    logic        b_en, b_flush, b_pop;
    logic [15:0] b_div;
    logic [7:0]  b_ch;
    logic [31:0] b_data;
    logic        b_empty, b_burst, b_ovf;
    logic [2:0]  b_level;
    logic [15:0] b_drop;

    sample_packer #(.DEPTH_LOG2(6), .BURST_WORDS(16)) u_a (
        .clk_pll(clk), .reset(reset), .enable(a_en), .flush(a_flush),
        .sample_div(a_div), .ch_data(a_ch), .rd_pop(a_pop),
        .rd_data(a_data), .rd_empty(a_empty), .rd_level(a_level),
        .burst_ready(a_burst), .overflow(a_ovf), .drop_ctr(a_drop));

    sample_packer #(.DEPTH_LOG2(2), .BURST_WORDS(4)) u_b (
        .clk_pll(clk), .reset(reset), .enable(b_en), .flush(b_flush),
        .sample_div(b_div), .ch_data(b_ch), .rd_pop(b_pop),
        .rd_data(b_data), .rd_empty(b_empty), .rd_level(b_level),
        .burst_ready(b_burst), .overflow(b_ovf), .drop_ctr(b_drop));

    int          sel;
    logic [31:0] o_data;
    logic        o_empty, o_burst, o_ovf;
    int          o_level;
    logic [15:0] o_drop;

    always_comb begin
        if (sel == 0) begin
            o_data = a_data; o_empty = a_empty; o_burst = a_burst;
            o_ovf = a_ovf; o_level = int'(a_level); o_drop = a_drop;
        end else begin
            o_data = b_data; o_empty = b_empty; o_burst = b_burst;
            o_ovf = b_ovf; o_level = int'(b_level); o_drop = b_drop;
        end
    end

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];
    logic [15:0] seq_m[2];
    int          exp_drop;

    typedef struct {
        logic [15:0] div;
        int          nrun;
        logic [7:0]  base;
        int          exp_level;
        logic [31:0] exp_last;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic v);
        if (sel == 0) a_en = v; else b_en = v;
    endtask
    task automatic set_pop(input logic v);
        if (sel == 0) a_pop = v; else b_pop = v;
    endtask
    task automatic set_flush(input logic v);
        if (sel == 0) a_flush = v; else b_flush = v;
    endtask
    task automatic set_div(input logic [15:0] v);
        if (sel == 0) a_div = v; else b_div = v;
    endtask
    task automatic set_ch(input logic [7:0] v);
        if (sel == 0) a_ch = v; else b_ch = v;
    endtask

    task automatic model_push(input logic [31:0] w, input int depth);
        if (sb.size() < depth) sb.push_back(w);
        else exp_drop++;
    endtask

    // Drives one capture session and predicts the words it pushes.
    task automatic run_session(input logic [15:0] div, input int nrun,
                               input logic [7:0] base, input int depth);
        logic [31:0] w;
        int          idx;
        set_div(div);
        set_en(1'b1);
        step();
        model_push({16'hCAFE, seq_m[sel]}, depth);
        seq_m[sel] = seq_m[sel] + 16'd1;
        step();
        w = '0;
        idx = 0;
        for (int k = 0; k < nrun; k++) begin
            set_ch(base + 8'(k));
            if (k % (int'(div) + 1) == 0) begin
                w[idx*8 +: 8] = base + 8'(k);
                idx++;
                if (idx == 4) begin
                    model_push(w, depth);
                    w = '0;
                    idx = 0;
                end
            end
            step();
        end
        set_en(1'b0);
        step();
        if (idx != 0) begin
            model_push(w, depth);
            step();
        end
    endtask

    task automatic drain(input string name, output logic [31:0] last);
        int          n;
        logic [31:0] exp;
        n = sb.size();
        last = '0;
        for (int i = 0; i < n; i++) begin
            exp = sb.pop_front();
            chk({name, " word"}, o_data, exp);
            last = o_data;
            set_pop(1'b1);
            step();
            set_pop(1'b0);
        end
        chk({name, " empty"}, 32'(o_empty), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last;
        vecs[0] = '{16'd0, 4, 8'h01, 2, 32'h04030201};
        vecs[1] = '{16'd2, 7, 8'haa, 2, 32'h00b0adaa};
        vecs[2] = '{16'd1, 9, 8'h10, 3, 32'h00000018};
        vecs[3] = '{16'd0, 8, 8'h20, 3, 32'h27262524};
        vecs[4] = '{16'd3, 2, 8'h40, 2, 32'h00000040};

        sel = 0;
        {a_en, a_flush, a_pop, a_div, a_ch} = '0;
        {b_en, b_flush, b_pop, b_div, b_ch} = '0;
        seq_m[0] = '0; seq_m[1] = '0;
        exp_drop = 0;
        reset = 1'b1;
        #1;
        chk("reset empty", 32'(a_empty), 32'd1);
        chk("reset level", 32'(a_level), 32'd0);
        chk("reset data", a_data, 32'd0);
        chk("reset burst", 32'(a_burst), 32'd0);
        chk("reset ovf", 32'(a_ovf), 32'd0);
        chk("reset drop", 32'(a_drop), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Table of sessions on the 64-word instance.
        for (int i = 0; i < 5; i++) begin
            run_session(vecs[i].div, vecs[i].nrun, vecs[i].base, 64);
            chk($sformatf("v%0d level", i), 32'(o_level), 32'(vecs[i].exp_level));
            chk($sformatf("v%0d header", i), o_data, 32'hCAFE0000 + 32'(i));
            drain($sformatf("v%0d", i), last);
            chk($sformatf("v%0d last", i), last, vecs[i].exp_last);
            step(); step(); step();
            chk($sformatf("v%0d idle empty", i), 32'(o_empty), 32'd1);
        end

        // Overflow on the 4-word instance.
        sel = 1;
        exp_drop = 0;
        run_session(16'd0, 32, 8'h00, 4);
        chk("ovf level", 32'(o_level), 32'd4);
        chk("ovf flag", 32'(o_ovf), 32'd1);
        chk("ovf drop_ctr", 32'(o_drop), 32'd5);
        chk("ovf drop model", 32'(o_drop), 32'(exp_drop));
        chk("ovf burst", 32'(o_burst), 32'd1);
        chk("ovf head", o_data, 32'hCAFE0000);

        // Header pushed into a full FIFO while the head is popped.
        set_div(16'd0);
        set_en(1'b1);
        step();
        chk("fullpop head", o_data, sb[0]);
        set_pop(1'b1);
        void'(sb.pop_front());
        sb.push_back({16'hCAFE, seq_m[1]});
        seq_m[1] = seq_m[1] + 16'd1;
        step();
        set_pop(1'b0);
        set_en(1'b0);
        step();
        chk("fullpop level", 32'(o_level), 32'd4);
        chk("fullpop drop_ctr", 32'(o_drop), 32'd5);
        drain("fullpop", last);
        chk("fullpop last", last, 32'hCAFE0001);

        // Flush mid-RUN with enable held high.
        set_en(1'b1);
        step();
        seq_m[1] = seq_m[1] + 16'd1;
        step();
        for (int k = 0; k < 5; k++) begin
            set_ch(8'h70 + 8'(k));
            step();
        end
        chk("preflush level", 32'(o_level), 32'd2);
        set_flush(1'b1);
        step();
        set_flush(1'b0);
        sb.delete();
        chk("flush empty", 32'(o_empty), 32'd1);
        chk("flush ovf", 32'(o_ovf), 32'd0);
        chk("flush drop", 32'(o_drop), 32'd0);
        for (int k = 0; k < 4; k++) step();
        chk("flush no restart", 32'(o_empty), 32'd1);
        set_en(1'b0);
        step();
        run_session(16'd0, 4, 8'h50, 4);
        chk("postflush header", o_data, 32'hCAFE0003);
        drain("postflush", last);
        chk("postflush last", last, 32'h53525150);

        // burst_ready threshold on the 64-word instance.
        sel = 0;
        run_session(16'd0, 56, 8'h00, 64);
        chk("burst level15", 32'(o_level), 32'd15);
        chk("burst low", 32'(o_burst), 32'd0);
        run_session(16'd0, 0, 8'h00, 64);
        chk("burst level16", 32'(o_level), 32'd16);
        chk("burst high", 32'(o_burst), 32'd1);
        chk("burst pop head", o_data, sb.pop_front());
        set_pop(1'b1);
        step();
        set_pop(1'b0);
        chk("burst fall level", 32'(o_level), 32'd15);
        chk("burst fall", 32'(o_burst), 32'd0);
        drain("burst", last);
        chk("burst last", last, 32'hCAFE0006);

        // Asynchronous reset in the middle of a session.
        set_div(16'd0);
        set_en(1'b1);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            set_ch(8'h80 + 8'(k));
            step();
        end
        chk("prereset level", 32'(o_level), 32'd3);
        #2;
        reset = 1'b1;
        set_en(1'b0);
        #1;
        chk("arst empty", 32'(o_empty), 32'd1);
        chk("arst level", 32'(o_level), 32'd0);
        chk("arst data", o_data, 32'd0);
        chk("arst burst", 32'(o_burst), 32'd0);
        chk("arst ovf", 32'(o_ovf), 32'd0);
        chk("arst drop", 32'(o_drop), 32'd0);
        step();
        step();
        reset = 1'b0;
        sb.delete();
        seq_m[0] = '0;
        seq_m[1] = '0;
        step();
        run_session(16'd0, 4, 8'h60, 64);
        chk("postreset header", o_data, 32'hCAFE0000);
        drain("postreset", last);
        chk("postreset last", last, 32'h63626160);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
